// File: rtl/next_pc_controller.sv
// Fetch-stage PC sequencer: trap > recover > (stall/halt hold) > prediction > sequential.
// Optional RSD_PC_MISALIGN_CHECK_EN rejects targets with nonzero bits [1:0] and halts fetch.
module next_pc_controller #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          FETCH_WIDTH  = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = 32'h0000_1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                trapValid,
    input  logic [PC_WIDTH-1:0] trapTarget,
    input  logic                recoverValid,
    input  logic [PC_WIDTH-1:0] recoverPC,
    input  logic                predValid,
    input  logic [PC_WIDTH-1:0] predTarget,
    input  logic                haltReq,
    input  logic                wakeReq,
    output logic [PC_WIDTH-1:0] pcOut,
    output logic                fetchValid,
    output logic                redirected,
    output logic                misalignFault
);

    localparam logic [PC_WIDTH-1:0] GROUP_BYTES = PC_WIDTH'(4 * FETCH_WIDTH);
    localparam logic [PC_WIDTH-1:0] GROUP_MASK  = GROUP_BYTES - PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] WORD_MASK   = PC_WIDTH'(3);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                redir_q, redir_d;
    logic                misalign_q, misalign_d;
    logic                fault_q, fault_d;

    logic                take_tgt;
    logic                tgt_is_redir;
    logic [PC_WIDTH-1:0] tgt;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = 1'b0;
        misalign_d   = 1'b0;
        fault_d      = fault_q;
        take_tgt     = 1'b0;
        tgt_is_redir = 1'b0;
        tgt          = '0;

        // A fault-induced halt can only be left through a trap.
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (haltReq && !wakeReq) state_d = HALTED;
            HALTED:  if (wakeReq && !fault_q) state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (trapValid) begin
            take_tgt     = 1'b1;
            tgt_is_redir = 1'b1;
            tgt          = trapTarget;
            state_d      = RUN;
            fault_d      = 1'b0;
        end else if (recoverValid) begin
            take_tgt     = 1'b1;
            tgt_is_redir = 1'b1;
            tgt          = recoverPC;
        end else if (!stall && state_q == RUN) begin
            if (predValid) begin
                take_tgt = 1'b1;
                tgt      = predTarget;
            end else begin
                pc_d = (pc_q & ~GROUP_MASK) + GROUP_BYTES;
            end
        end

        if (take_tgt) begin
`ifdef RSD_PC_MISALIGN_CHECK_EN
            if ((tgt & WORD_MASK) != '0) begin
                misalign_d = 1'b1;
                state_d    = HALTED;
                fault_d    = 1'b1;
            end else begin
                pc_d    = tgt;
                redir_d = tgt_is_redir;
            end
`else
            pc_d    = tgt & ~WORD_MASK;
            redir_d = tgt_is_redir;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            redir_q    <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_q    <= redir_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    assign pcOut      = pc_q;
    assign fetchValid = (state_q == RUN) && !stall;
    assign redirected = redir_q;
`ifdef RSD_PC_MISALIGN_CHECK_EN
    assign misalignFault = misalign_q;
`else
    assign misalignFault = 1'b0;
`endif

endmodule

// File: tb/tb_next_pc_controller.sv
// Directed-vector bench for next_pc_controller; stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_next_pc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trapValid;
    logic [31:0] trapTarget;
    logic        recoverValid;
    logic [31:0] recoverPC;
    logic        predValid;
    logic [31:0] predTarget;
    logic        haltReq;
    logic        wakeReq;
    logic [31:0] pcOut;
    logic        fetchValid;
    logic        redirected;
    logic        misalignFault;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic        red;
        logic        mf;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    next_pc_controller #(
        .PC_WIDTH    (32),
        .FETCH_WIDTH (2),
        .RESET_VECTOR(32'h0000_1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .trapValid    (trapValid),
        .trapTarget   (trapTarget),
        .recoverValid (recoverValid),
        .recoverPC    (recoverPC),
        .predValid    (predValid),
        .predTarget   (predTarget),
        .haltReq      (haltReq),
        .wakeReq      (wakeReq),
        .pcOut        (pcOut),
        .fetchValid   (fetchValid),
        .redirected   (redirected),
        .misalignFault(misalignFault)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (pcOut !== e.pc || fetchValid !== e.fv || redirected !== e.red ||
                misalignFault !== e.mf) begin
                n_fail++;
                $display("FAIL %s: got pc=%h fv=%b red=%b mf=%b, want pc=%h fv=%b red=%b mf=%b",
                         e.name, pcOut, fetchValid, redirected, misalignFault,
                         e.pc, e.fv, e.red, e.mf);
            end
        end
    end

    task automatic idle();
        rst          = 1'b1;
        stall        = 1'b0;
        trapValid    = 1'b0;
        trapTarget   = '0;
        recoverValid = 1'b0;
        recoverPC    = '0;
        predValid    = 1'b0;
        predTarget   = '0;
        haltReq      = 1'b0;
        wakeReq      = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] pc, input logic fv,
                       input logic red, input logic mf);
        exp_t e;
        e.name = nm;
        e.pc   = pc;
        e.fv   = fv;
        e.red  = red;
        e.mf   = mf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(); rst = 1'b0;                      chk("reset",        32'h1000, 0, 0, 0);
        idle();                                  chk("boot",         32'h1000, 0, 0, 0);
        idle();                                  chk("first_fetch",  32'h1000, 1, 0, 0);
        // stall at 0x1008 with an ignored prediction
        for (int i = 0; i < 3; i++) begin
            idle(); stall = 1; predValid = 1; predTarget = 32'h2000;
            chk("stall_hold", 32'h1008, 0, 0, 0);
        end
        idle(); predValid = 1; predTarget = 32'h2000; chk("stall_release", 32'h1008, 1, 0, 0);
        idle();                                  chk("pred_taken",   32'h2000, 1, 0, 0);
        idle(); stall = 1; trapValid = 1; trapTarget = 32'h8000;
        recoverValid = 1; recoverPC = 32'h3000; predValid = 1; predTarget = 32'h2000;
                                                 chk("prio_pre",     32'h2008, 0, 0, 0);
        idle();                                  chk("trap_taken",   32'h8000, 1, 1, 0);
        idle(); haltReq = 1;                     chk("redir_pulse",  32'h8008, 1, 0, 0);
        idle(); recoverValid = 1; recoverPC = 32'h4000; chk("halted", 32'h8010, 0, 0, 0);
        idle();                                  chk("halt_recover", 32'h4000, 0, 1, 0);
        idle(); wakeReq = 1;                     chk("still_halted", 32'h4000, 0, 0, 0);
        idle();                                  chk("woken",        32'h4000, 1, 0, 0);
        idle(); haltReq = 1; wakeReq = 1;        chk("halt_wake_pre", 32'h4008, 1, 0, 0);
        idle(); trapValid = 1; trapTarget = 32'h9000; haltReq = 1;
                                                 chk("halt_wake_run", 32'h4010, 1, 0, 0);
        idle(); recoverValid = 1; recoverPC = 32'hFFFF_FFF8;
                                                 chk("trap_beats_halt", 32'h9000, 1, 1, 0);
        idle();                                  chk("near_wrap",    32'hFFFF_FFF8, 1, 1, 0);
        idle(); recoverValid = 1; recoverPC = 32'h1004; chk("wrapped", 32'h0000_0000, 1, 0, 0);
        idle();                                  chk("mid_group",    32'h1004, 1, 1, 0);
        idle();                                  chk("realigned",    32'h1008, 1, 0, 0);
        idle(); recoverValid = 1; recoverPC = 32'h1002; chk("pre_misalign", 32'h1010, 1, 0, 0);
`ifdef RSD_PC_MISALIGN_CHECK_EN
        idle(); wakeReq = 1;                     chk("misalign_fault", 32'h1010, 0, 0, 1);
        idle(); trapValid = 1; trapTarget = 32'h5000; chk("fault_halted", 32'h1010, 0, 0, 0);
`else
        idle();                                  chk("misalign_forced", 32'h1000, 1, 1, 0);
        idle(); trapValid = 1; trapTarget = 32'h5000; chk("after_forced", 32'h1008, 1, 0, 0);
`endif
        idle();                                  chk("trap_recovers", 32'h5000, 1, 1, 0);
        idle(); stall = 1; rst = 1'b0;           chk("async_reset",  32'h1000, 0, 0, 0);
        idle();                                  chk("reboot",       32'h1000, 0, 0, 0);
        idle();                                  chk("refetch",      32'h1000, 1, 0, 0);
        idle();                                  chk("seq_after_reset", 32'h1008, 1, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/next_pc_controller.md
# next_pc_controller

Sequences the fetch-stage PC register. Every cycle it picks the next fetch address from four sources: trap, recovery, branch prediction and the sequential fetch group. It owns the PC flop and applies stalls. A halt/wake state machine gates fetch validity. It sits at the head of the fetch stage, feeding I-cache and branch predictor lookup.

## Interface
- PC_WIDTH, 32: PC width in bits.
- FETCH_WIDTH, 2: instructions per fetch group; must be a power of two. Group size G = 4*FETCH_WIDTH bytes.
- RESET_VECTOR, 32'h0000_1000: PC value loaded on reset. Must be G-aligned.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  fetch stage cannot accept a new group; hold PC.
- trapValid  in  1  exception/interrupt redirect.
- trapTarget  in  PC_WIDTH  trap handler address.
- recoverValid  in  1  branch mispredict / pipeline flush redirect.
- recoverPC  in  PC_WIDTH  recovery address.
- predValid  in  1  predictor says the current group contains a taken branch.
- predTarget  in  PC_WIDTH  predicted target.
- haltReq  in  1  WFI retired; stop fetching.
- wakeReq  in  1  interrupt pending; resume fetching.
- pcOut  out  PC_WIDTH  current fetch PC (registered).
- fetchValid  out  1  pcOut is a group to be fetched this cycle.
- redirected  out  1  registered pulse: pcOut was loaded from trap or recover in the previous edge.
- misalignFault  out  1  registered pulse (macro only, see Configuration).

## Operation
- States: BOOT, RUN, HALTED.
  - BOOT→RUN after one cycle.
  - RUN→HALTED on haltReq when trapValid=0.
  - HALTED→RUN on wakeReq or trapValid.
  - recoverValid in HALTED updates pcOut but stays HALTED.
- fetchValid = (state==RUN) && !stall. It is combinational from the state and stall.
- Next-PC priority, highest first:
  1. trapValid → trapTarget (any state, ignores stall).
  2. recoverValid → recoverPC (any state, ignores stall).
  3. stall or state≠RUN → hold.
  4. predValid → predTarget.
  5. sequential → (pcOut & ~(G-1)) + G.
- The sequential path realigns a mid-group PC to the next group boundary.
- Addition is modulo 2^PC_WIDTH. The carry out is discarded, so 0xFFFF_FFF8 + 8 wraps to 0.
- predValid is ignored when it arrives during stall or in a non-RUN state. The predictor re-asserts it for the held PC.
- trapValid together with haltReq: the trap wins, PC goes to trapTarget and the state is RUN.
- haltReq and wakeReq in the same cycle in RUN: the state stays RUN.
- redirected = 1 for exactly one cycle after an edge where priority 1 or 2 was taken.

## Timing
- The PC flop is edge-triggered. A source selected in cycle N appears on pcOut in cycle N+1 (1-cycle latency).
- Reset values:
  - pcOut = RESET_VECTOR
  - state = BOOT
  - fetchValid = 0
  - redirected = 0
  - misalignFault = 0
- First fetch: in the first cycle after rst deasserts the state is BOOT and fetchValid = 0. The second cycle is RUN with fetchValid=1 at RESET_VECTOR.
- Asserting rst mid-operation forces all of the above values asynchronously, including during HALTED or stall.
- No combinational path from any redirect input to pcOut. Only stall→fetchValid is combinational.

## Configuration
- RSD_PC_MISALIGN_CHECK_EN defined:
  - Trap, recover and pred targets with bits [1:0]≠0 are not loaded. PC holds.
  - misalignFault pulses high for one cycle after the edge.
  - The state goes to HALTED until trapValid arrives.
- RSD_PC_MISALIGN_CHECK_EN undefined:
  - Bits [1:0] of every loaded target are forced to 0.
  - misalignFault is tied to 0.

## Test plan
- Reset release, no other inputs (FETCH_WIDTH=2): cycle 1 fetchValid=0, pcOut=0x1000; cycle 2 fetchValid=1, pcOut=0x1000; then 0x1008, 0x1010 on following cycles.
- pcOut=0x1008, stall=1 for 3 cycles with predValid=1, predTarget=0x2000: pcOut holds 0x1008 and fetchValid=0 throughout. Release stall with predValid=1 → next pcOut=0x2000.
- Same cycle trapValid (0x8000), recoverValid (0x3000), predValid (0x2000), stall=1: pcOut=0x8000 next cycle, redirected=1 for one cycle.
- haltReq in RUN → HALTED, fetchValid=0. recoverValid to 0x4000 → pcOut=0x4000, still HALTED. wakeReq → RUN, fetchValid=1 at 0x4000.
- pcOut=0xFFFF_FFF8 sequential → 0x0000_0000. recoverPC=0x1004 then sequential → 0x1008.
- With the macro, recoverPC=0x1002 → pcOut unchanged, misalignFault=1 for one cycle, HALTED. Without the macro → pcOut=0x1000, misalignFault=0.
